ring_router_multi: RTL and testbench
====================================

# ring_router_multi

Parametrised ring router serving several local endpoints on one dual-ring stop. Packets from either ring input whose destination falls in the router's contiguous ID range go to the matching local port; all other packets are forwarded. Local endpoints inject onto ring 0 through a quota-limited arbiter, which guarantees injection bandwidth under saturated ring traffic. Each ring output is buffered. The block replaces the single-endpoint router at ring stops that host more than one debug module.

## Interface
- BUFFER_SIZE, 4: depth in flits of each ring output FIFO; must be ≥2.
- NUM_LOCAL, 2: number of local endpoints, range 1..8; endpoint k owns ID `id+k`.
- INJECT_QUOTA, 4: maximum consecutive ring-0 forwarded packets granted while any local input is pending; must be ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- id  in  10  base ID; must be stable outside reset.
- ring_in0, ring_in1  dii_channel slave  16+valid+last+ready  ring inputs.
- ring_out0, ring_out1  dii_channel master  16+valid+last+ready  buffered ring outputs.
- local_in[NUM_LOCAL]  dii_channel slave  16+valid+last+ready  endpoint injection; all traffic goes to ring 0.
- local_out[NUM_LOCAL]  dii_channel master  16+valid+last+ready  endpoint delivery.

## Operation
- Flit transfer occurs when valid && ready. A packet is a run of flits ending with last=1. The first flit (header) carries the destination in data[9:0].
- Ring demux, one per ring input:
  - States IDLE and BUSY(target).
  - In IDLE, the header is decoded combinationally. off = dest − id, 10-bit unsigned. If dest ≥ id and off < NUM_LOCAL, target is local k = off; otherwise target is ring forward.
  - The header passes in the same cycle. ready comes from the target.
  - The demux enters BUSY after a non-last header is accepted and returns to IDLE when a flit with last=1 is accepted. A single-flit packet stays in IDLE.
- Ring 1 forward goes straight to the ring_out1 FIFO. Ring 0 forward competes for ring_out0.
- Local output mux k:
  - Inputs are ring0→k and ring1→k.
  - Packet-level round-robin: the grant locks on the first accepted flit and is held until last is accepted.
  - After each completed packet the priority pointer moves to the other input. When both inputs are valid in IDLE, the pointer side wins.
- Ring-0 injection arbiter:
  - Candidates are ring0-forward and local_in[0..NUM_LOCAL−1]. Arbitration is packet-level with a lock as above.
  - Default: ring0-forward has priority.
  - Counter fwd_cnt, width clog2(INJECT_QUOTA+1), increments when a ring packet is granted while any local_in is valid.
  - When fwd_cnt == INJECT_QUOTA and a local is valid, the next grant goes to a local input even if ring is valid.
  - fwd_cnt clears on any local grant, and at any arbitration with no local valid.
  - Among locals: round-robin pointer. The first valid at or after the pointer wins; the pointer moves to winner+1, mod NUM_LOCAL.
- Ring output FIFOs:
  - Registered, depth BUFFER_SIZE.
  - in.ready = !full; no write-through when full. A simultaneous push and pop is legal at any non-full occupancy.
  - out.valid = !empty.
- Reset state:
  - All valid outputs and all ready outputs are 0.
  - FIFOs empty.
  - Demuxes IDLE.
  - Mux pointers at in0 / local 0.
  - fwd_cnt = 0.
- Reset asserted mid-packet discards in-flight state, including partial packets. The bench must not expect recovery of those packets.

## Timing
- Ring-in to local_out: 0 cycles, combinational valid, data and ready.
- Ring/local-in to ring_out: 1 cycle minimum. A flit pushed in cycle n is valid on ring_out in cycle n+1 when the FIFO was empty.
- Arbitration decisions and pointer/counter updates take effect the cycle after the deciding transfer.
- Non-granted inputs see ready=0.
- Throughput: 1 flit/cycle per output when not back-pressured.

## Test plan
- id=0x040, NUM_LOCAL=2: ring_in0 packet dest 0x041, 3 flits → local_out[1] receives 3 flits in the same cycles; ring_out0 stays idle.
- Dest 0x03F and dest 0x042 on ring_in1 → both forwarded to ring_out1, 1 cycle later, order preserved, nothing on local outputs.
- Both rings send continuous 2-flit packets to dest 0x040 → local_out[0] alternates ring0, ring1, ring0…; no interleaving of flits within a packet.
- INJECT_QUOTA=4, ring_in0 saturated with forward traffic, local_in[0] and local_in[1] always valid → on ring_out0, exactly 4 ring packets between local packets; locals alternate 0, 1, 0.
- BUFFER_SIZE=4, ring_out1.ready=0 for 10 cycles with streaming input → ring_in1.ready drops after 4 accepts; after ready=1, flits drain in order with no loss or duplication.
- rst pulsed for 1 cycle in the middle of a 5-flit packet → next cycle all outputs are invalid, FIFOs empty, and a fresh packet afterwards routes correctly.

Source files
------------

// File: rtl/ring_router_multi.sv
// Dual-ring stop serving NUM_LOCAL endpoints that own IDs id..id+NUM_LOCAL-1.
// Ring flits demux to a local port or forward; ring_out0 arbitrates forward vs local injection.
module ring_router_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign rdata   = mem[rp];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (do_pop)  rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
endmodule

module ring_router_multi #(
    parameter int BUFFER_SIZE  = 4,
    parameter int NUM_LOCAL    = 2,
    parameter int INJECT_QUOTA = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  id,
    input  logic [15:0]                 ring_in0_data,
    input  logic                        ring_in0_valid,
    input  logic                        ring_in0_last,
    output logic                        ring_in0_ready,
    input  logic [15:0]                 ring_in1_data,
    input  logic                        ring_in1_valid,
    input  logic                        ring_in1_last,
    output logic                        ring_in1_ready,
    output logic [15:0]                 ring_out0_data,
    output logic                        ring_out0_valid,
    output logic                        ring_out0_last,
    input  logic                        ring_out0_ready,
    output logic [15:0]                 ring_out1_data,
    output logic                        ring_out1_valid,
    output logic                        ring_out1_last,
    input  logic                        ring_out1_ready,
    input  logic [NUM_LOCAL-1:0][15:0]  local_in_data,
    input  logic [NUM_LOCAL-1:0]        local_in_valid,
    input  logic [NUM_LOCAL-1:0]        local_in_last,
    output logic [NUM_LOCAL-1:0]        local_in_ready,
    output logic [NUM_LOCAL-1:0][15:0]  local_out_data,
    output logic [NUM_LOCAL-1:0]        local_out_valid,
    output logic [NUM_LOCAL-1:0]        local_out_last,
    input  logic [NUM_LOCAL-1:0]        local_out_ready
);
    localparam int TW = $clog2(NUM_LOCAL + 1);
    localparam int LW = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
    localparam int CW = $clog2(INJECT_QUOTA + 1);
    localparam logic [TW-1:0] FWD = TW'(NUM_LOCAL);

    logic [1:0][15:0]          rd;
    logic [1:0]                rv, rl, rr, busy;
    logic [1:0][9:0]           off;
    logic [1:0][TW-1:0]        dec, cur, tgt;
    logic [1:0][NUM_LOCAL-1:0] loc_rdy;
    logic                      fwd_rdy0, fwd_rdy1;

    assign rd = {ring_in1_data, ring_in0_data};
    assign rv = {ring_in1_valid, ring_in0_valid};
    assign rl = {ring_in1_last, ring_in0_last};
    assign ring_in0_ready = rr[0];
    assign ring_in1_ready = rr[1];

    // Target code NUM_LOCAL means "forward along the ring".
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            off[r] = rd[r][9:0] - id;
            dec[r] = (rd[r][9:0] >= id && off[r] < 10'(NUM_LOCAL)) ? off[r][TW-1:0] : FWD;
            cur[r] = busy[r] ? tgt[r] : dec[r];
        end
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rr[r] = (cur[r] == FWD) && ((r == 0) ? fwd_rdy0 : fwd_rdy1);
            for (int k = 0; k < NUM_LOCAL; k++)
                if (cur[r] == TW'(k)) rr[r] = loc_rdy[r][k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            tgt  <= '0;
        end else begin
            for (int r = 0; r < 2; r++)
                if (rv[r] && rr[r]) begin
                    if (rl[r]) busy[r] <= 1'b0;
                    else if (!busy[r]) begin
                        busy[r] <= 1'b1;
                        tgt[r]  <= dec[r];
                    end
                end
        end
    end

    // Local output muxes: packet-locked round-robin between ring 0 and ring 1.
    logic [NUM_LOCAL-1:0] va, vb, msel, mlock, mlsel, mptr, lo_valid;

    always_comb begin
        for (int k = 0; k < NUM_LOCAL; k++) begin
            va[k]             = rv[0] && (cur[0] == TW'(k));
            vb[k]             = rv[1] && (cur[1] == TW'(k));
            msel[k]           = mlock[k] ? mlsel[k] : ((va[k] && vb[k]) ? mptr[k] : vb[k]);
            lo_valid[k]       = msel[k] ? vb[k] : va[k];
            local_out_data[k] = rd[msel[k]];
            local_out_last[k] = rl[msel[k]];
            loc_rdy[0][k]     = local_out_ready[k] && !msel[k] && !rst;
            loc_rdy[1][k]     = local_out_ready[k] && msel[k] && !rst;
        end
    end

    assign local_out_valid = rst ? '0 : lo_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mlock <= '0;
            mlsel <= '0;
            mptr  <= '0;
        end else begin
            for (int k = 0; k < NUM_LOCAL; k++)
                if (lo_valid[k] && local_out_ready[k]) begin
                    mlock[k] <= !local_out_last[k];
                    mlsel[k] <= msel[k];
                    if (local_out_last[k]) mptr[k] <= !msel[k];
                end
        end
    end

    // Ring-0 injection arbiter: ring forward wins unless the quota of
    // consecutive ring grants with locals waiting has been used up.
    logic          fwd_v, any_loc, a_ring, a_ring_q, alock, in0_valid, in0_last, full0, full1;
    logic [15:0]   in0_data;
    logic [LW-1:0] win, a_loc, a_loc_q, aptr;
    logic [CW-1:0] fwd_cnt;

    always_comb begin
        fwd_v   = rv[0] && (cur[0] == FWD);
        any_loc = |local_in_valid;
        win     = aptr;
        for (int k = NUM_LOCAL - 1; k >= 0; k--)
            if (local_in_valid[k]) win = LW'(k);
        for (int k = NUM_LOCAL - 1; k >= 0; k--)
            if (local_in_valid[k] && LW'(k) >= aptr) win = LW'(k);
        if (alock) begin
            a_ring = a_ring_q;
            a_loc  = a_loc_q;
        end else begin
            a_ring = fwd_v && !((fwd_cnt == CW'(INJECT_QUOTA)) && any_loc);
            a_loc  = win;
        end
        in0_valid      = a_ring && fwd_v;
        in0_data       = rd[0];
        in0_last       = rl[0];
        local_in_ready = '0;
        for (int k = 0; k < NUM_LOCAL; k++)
            if (!a_ring && a_loc == LW'(k)) begin
                in0_valid         = local_in_valid[k];
                in0_data          = local_in_data[k];
                in0_last          = local_in_last[k];
                local_in_ready[k] = !full0 && !rst;
            end
        fwd_rdy0 = a_ring && !full0 && !rst;
        fwd_rdy1 = !full1 && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alock    <= 1'b0;
            a_ring_q <= 1'b0;
            a_loc_q  <= '0;
            aptr     <= '0;
            fwd_cnt  <= '0;
        end else if (in0_valid && !full0) begin
            if (!alock) begin
                if (a_ring) fwd_cnt <= any_loc ? fwd_cnt + 1'b1 : '0;
                else begin
                    fwd_cnt <= '0;
                    aptr    <= (a_loc == LW'(NUM_LOCAL - 1)) ? '0 : a_loc + 1'b1;
                end
            end
            alock    <= !in0_last;
            a_ring_q <= a_ring;
            a_loc_q  <= a_loc;
        end
    end

    logic empty0, empty1;

    ring_router_fifo #(.DEPTH(BUFFER_SIZE), .W(17)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (in0_valid),
        .wdata ({in0_last, in0_data}),
        .full  (full0),
        .pop   (ring_out0_ready),
        .rdata ({ring_out0_last, ring_out0_data}),
        .empty (empty0)
    );

    ring_router_fifo #(.DEPTH(BUFFER_SIZE), .W(17)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (rv[1] && (cur[1] == FWD)),
        .wdata ({rl[1], rd[1]}),
        .full  (full1),
        .pop   (ring_out1_ready),
        .rdata ({ring_out1_last, ring_out1_data}),
        .empty (empty1)
    );

    assign ring_out0_valid = !empty0 && !rst;
    assign ring_out1_valid = !empty1 && !rst;
endmodule

// File: tb/tb_ring_router_multi.sv
// Directed bench for ring_router_multi with id=0x040, two locals, quota 4, 4-deep FIFOs.
module tb_ring_router_multi;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [9:0]       id = 10'h040;
    logic [15:0]      ring_in0_data = '0, ring_in1_data = '0;
    logic             ring_in0_valid = 1'b0, ring_in0_last = 1'b0, ring_in0_ready;
    logic             ring_in1_valid = 1'b0, ring_in1_last = 1'b0, ring_in1_ready;
    logic [15:0]      ring_out0_data, ring_out1_data;
    logic             ring_out0_valid, ring_out0_last, ring_out0_ready = 1'b1;
    logic             ring_out1_valid, ring_out1_last, ring_out1_ready = 1'b1;
    logic [1:0][15:0] local_in_data = '0;
    logic [1:0]       local_in_valid = '0, local_in_last = '0, local_in_ready;
    logic [1:0][15:0] local_out_data;
    logic [1:0]       local_out_valid, local_out_last;
    logic [1:0]       local_out_ready = 2'b11;

    int tests = 0;
    int fails = 0;

    ring_router_multi #(.BUFFER_SIZE(4), .NUM_LOCAL(2), .INJECT_QUOTA(4)) dut (
        .clk(clk), .rst(rst), .id(id),
        .ring_in0_data(ring_in0_data), .ring_in0_valid(ring_in0_valid),
        .ring_in0_last(ring_in0_last), .ring_in0_ready(ring_in0_ready),
        .ring_in1_data(ring_in1_data), .ring_in1_valid(ring_in1_valid),
        .ring_in1_last(ring_in1_last), .ring_in1_ready(ring_in1_ready),
        .ring_out0_data(ring_out0_data), .ring_out0_valid(ring_out0_valid),
        .ring_out0_last(ring_out0_last), .ring_out0_ready(ring_out0_ready),
        .ring_out1_data(ring_out1_data), .ring_out1_valid(ring_out1_valid),
        .ring_out1_last(ring_out1_last), .ring_out1_ready(ring_out1_ready),
        .local_in_data(local_in_data), .local_in_valid(local_in_valid),
        .local_in_last(local_in_last), .local_in_ready(local_in_ready),
        .local_out_data(local_out_data), .local_out_valid(local_out_valid),
        .local_out_last(local_out_last), .local_out_ready(local_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        ring_in0_valid = 1'b0; ring_in0_last = 1'b0;
        ring_in1_valid = 1'b0; ring_in1_last = 1'b0;
        local_in_valid = '0;   local_in_last = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] mk_rr(int ring, int pk, int ix);
        if (ix == 0) return {4'(ring + 1), 2'(pk), 10'h040};
        return {4'hB, 4'(ring), 8'(pk)};
    endfunction

    task automatic test_reset();
        idle_inputs();
        ring_in0_valid = 1'b1; ring_in0_data = 16'h0040; ring_in0_last = 1'b1;
        local_in_valid = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({ring_in0_ready, ring_in1_ready, local_in_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: got %b, expected 0000", {ring_in0_ready, ring_in1_ready, local_in_ready});
        end
        tests++;
        if ({ring_out0_valid, ring_out1_valid, local_out_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_valid: got %b, expected 0000", {ring_out0_valid, ring_out1_valid, local_out_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({ring_out0_valid, ring_out1_valid, local_out_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL post_reset_empty: got %b, expected 0000", {ring_out0_valid, ring_out1_valid, local_out_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_local_deliver();
        logic [15:0] f [3];
        f[0] = 16'h1041; f[1] = 16'h2222; f[2] = 16'h3333;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            ring_in0_valid = 1'b1; ring_in0_data = f[i]; ring_in0_last = (i == 2);
            @(negedge clk);
            tests++;
            if ({local_out_valid, local_out_data[1], local_out_last[1], ring_in0_ready, ring_out0_valid}
                !== {2'b10, f[i], (i == 2), 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL local_deliver flit %0d: got v=%b d=%h l=%b rdy=%b o0v=%b, expected v=10 d=%h l=%b rdy=1 o0v=0",
                         i, local_out_valid, local_out_data[1], local_out_last[1], ring_in0_ready, ring_out0_valid, f[i], (i == 2));
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({ring_out0_valid, local_out_valid} !== 3'b000) begin
            fails++;
            $display("FAIL local_deliver_after: got %b, expected 000", {ring_out0_valid, local_out_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        pulse_reset();
        ring_in1_valid = 1'b1; ring_in1_data = 16'h503F; ring_in1_last = 1'b1;
        @(negedge clk);
        tests++;
        if ({ring_in1_ready, ring_out1_valid, local_out_valid} !== 4'b1000) begin
            fails++;
            $display("FAIL fwd_cycle0: got %b, expected 1000", {ring_in1_ready, ring_out1_valid, local_out_valid});
        end
        @(posedge clk); #1;
        ring_in1_data = 16'h6042;
        @(negedge clk);
        tests++;
        if ({ring_out1_valid, ring_out1_data, ring_out1_last, local_out_valid} !== {1'b1, 16'h503F, 1'b1, 2'b00}) begin
            fails++;
            $display("FAIL fwd_first: got v=%b d=%h l=%b lo=%b, expected v=1 d=503f l=1 lo=00",
                     ring_out1_valid, ring_out1_data, ring_out1_last, local_out_valid);
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({ring_out1_valid, ring_out1_data, local_out_valid} !== {1'b1, 16'h6042, 2'b00}) begin
            fails++;
            $display("FAIL fwd_second: got v=%b d=%h lo=%b, expected v=1 d=6042 lo=00",
                     ring_out1_valid, ring_out1_data, local_out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({ring_out1_valid, ring_out0_valid} !== 2'b00) begin
            fails++;
            $display("FAIL fwd_drained: got %b, expected 00", {ring_out1_valid, ring_out0_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_local_rr();
        int pk [2];
        int ix [2];
        logic r0, r1;
        int es, ep, ef;
        pk[0] = 0; pk[1] = 0; ix[0] = 0; ix[1] = 0;
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            ring_in0_valid = 1'b1; ring_in0_data = mk_rr(0, pk[0], ix[0]); ring_in0_last = (ix[0] == 1);
            ring_in1_valid = 1'b1; ring_in1_data = mk_rr(1, pk[1], ix[1]); ring_in1_last = (ix[1] == 1);
            @(negedge clk);
            es = (c / 2) % 2; ep = c / 4; ef = c % 2;
            tests++;
            if ({local_out_valid, local_out_data[0], local_out_last[0], ring_in0_ready, ring_in1_ready}
                !== {2'b01, mk_rr(es, ep, ef), (ef == 1), (es == 0), (es == 1)}) begin
                fails++;
                $display("FAIL local_rr cycle %0d: got v=%b d=%h l=%b rdy=%b%b, expected ring%0d d=%h",
                         c, local_out_valid, local_out_data[0], local_out_last[0], ring_in0_ready, ring_in1_ready,
                         es, mk_rr(es, ep, ef));
            end
            r0 = ring_in0_ready; r1 = ring_in1_ready;
            @(posedge clk); #1;
            if (r0) begin if (ix[0] == 1) begin ix[0] = 0; pk[0]++; end else ix[0] = 1; end
            if (r1) begin if (ix[1] == 1) begin ix[1] = 0; pk[1]++; end else ix[1] = 1; end
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_quota();
        int rn;
        int lm [2];
        logic [15:0] got [$];
        logic [15:0] exp_d;
        logic r0;
        logic [1:0] lr;
        int j;
        rn = 0; lm[0] = 0; lm[1] = 0;
        pulse_reset();
        for (int c = 0; c < 25; c++) begin
            ring_in0_valid = 1'b1; ring_in0_data = {6'(rn), 10'h100}; ring_in0_last = 1'b1;
            local_in_valid = 2'b11; local_in_last = 2'b11;
            for (int k = 0; k < 2; k++) local_in_data[k] = {4'hF, 4'(k), 8'(lm[k])};
            @(negedge clk);
            if (ring_out0_valid) got.push_back(ring_out0_data);
            r0 = ring_in0_ready; lr = local_in_ready;
            @(posedge clk); #1;
            if (r0) rn++;
            for (int k = 0; k < 2; k++) if (lr[k]) lm[k]++;
        end
        idle_inputs();
        tests++;
        if (got.size() < 15) begin
            fails++;
            $display("FAIL quota_count: got %0d flits on ring_out0, expected at least 15", got.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (i % 5 == 4) begin
                    j = i / 5;
                    exp_d = {4'hF, 4'(j % 2), 8'(j / 2)};
                end else exp_d = {6'(i - i / 5), 10'h100};
                tests++;
                if (got[i] !== exp_d) begin
                    fails++;
                    $display("FAIL quota_order slot %0d: got %h, expected %h", i, got[i], exp_d);
                end
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int sent;
        logic [15:0] got [$];
        logic rdy;
        sent = 0;
        pulse_reset();
        ring_out1_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ring_in1_valid = 1'b1; ring_in1_data = {6'(sent), 10'h200}; ring_in1_last = 1'b1;
            @(negedge clk);
            tests++;
            if (ring_in1_ready !== (c < 4)) begin
                fails++;
                $display("FAIL bp_ready cycle %0d: got %b, expected %b", c, ring_in1_ready, (c < 4));
            end
            rdy = ring_in1_ready;
            @(posedge clk); #1;
            if (rdy) sent++;
        end
        tests++;
        if (sent != 4) begin
            fails++;
            $display("FAIL bp_accepts: got %0d, expected 4", sent);
        end
        ring_out1_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 6) begin
                ring_in1_valid = 1'b1; ring_in1_data = {6'(sent), 10'h200}; ring_in1_last = 1'b1;
            end else ring_in1_valid = 1'b0;
            @(negedge clk);
            if (ring_out1_valid) got.push_back(ring_out1_data);
            rdy = ring_in1_ready && ring_in1_valid;
            @(posedge clk); #1;
            if (rdy) sent++;
        end
        tests++;
        if (got.size() != sent) begin
            fails++;
            $display("FAIL bp_drain_count: got %0d flits out, expected %0d", got.size(), sent);
        end
        for (int i = 0; i < got.size(); i++) begin
            tests++;
            if (got[i] !== {6'(i), 10'h200}) begin
                fails++;
                $display("FAIL bp_order %0d: got %h, expected %h", i, got[i], {6'(i), 10'h200});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        ring_out0_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ring_in0_valid = 1'b1; ring_in0_last = 1'b0;
            ring_in0_data = (i == 0) ? 16'h0300 : 16'hAA01;
            @(posedge clk); #1;
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({ring_out0_valid, ring_in0_ready} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_during: got %b, expected 00", {ring_out0_valid, ring_in0_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({ring_out0_valid, ring_out1_valid, local_out_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_after: got %b, expected 0000", {ring_out0_valid, ring_out1_valid, local_out_valid});
        end
        @(posedge clk); #1;
        ring_out0_ready = 1'b1;
        ring_in0_valid = 1'b1; ring_in0_data = 16'h7040; ring_in0_last = 1'b1;
        @(negedge clk);
        tests++;
        if ({local_out_valid, local_out_data[0], ring_in0_ready, ring_out0_valid} !== {2'b01, 16'h7040, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_fresh_local: got v=%b d=%h rdy=%b o0v=%b, expected v=01 d=7040 rdy=1 o0v=0",
                     local_out_valid, local_out_data[0], ring_in0_ready, ring_out0_valid);
        end
        @(posedge clk); #1;
        ring_in0_data = 16'h8123;
        @(negedge clk);
        tests++;
        if ({ring_in0_ready, local_out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL rst_mid_fresh_fwd_in: got %b, expected 100", {ring_in0_ready, local_out_valid});
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if ({ring_out0_valid, ring_out0_data, ring_out0_last} !== {1'b1, 16'h8123, 1'b1}) begin
            fails++;
            $display("FAIL rst_mid_fresh_fwd_out: got v=%b d=%h l=%b, expected v=1 d=8123 l=1",
                     ring_out0_valid, ring_out0_data, ring_out0_last);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_local_deliver();
        test_forward();
        test_local_rr();
        test_quota();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
